// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Holds the state encoding, the mcause codes, the mstatus bit positions
// and the record the cause encoder hands back to the top level.
package trap_ctrl_pkg;

    localparam int XLEN     = 64;
    localparam int MTIE_BIT = 7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = 64'd3;
    localparam logic [XLEN-1:0] CAUSE_ECALL_M = 64'd11;
    localparam logic [XLEN-1:0] CAUSE_MTIMER  = {1'b1, 63'd7};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_EXIT  = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

    typedef struct packed {
        logic            take;
        logic            is_irq;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } trap_info_t;

endpackage

// File: rtl/trap_ctrl_cause_enc.sv
// trap_cause_enc: combinational priority encoder for the commit-stage trap
// sources. The timer interrupt beats every exception; among exceptions the
// order is illegal > ebreak > ecall, and only the winner is reported.
module trap_cause_enc
    import trap_ctrl_pkg::*;
(
    input  logic            inst_valid,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            illegal,
    input  logic            timer_irq,
    input  logic            mie_mtie,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] inst_pc,
    input  logic [31:0]     inst,
    output trap_info_t      info
);

    // Pick the highest-priority trap and the cause/tval it reports
    always_comb begin
        info = '0;
        if (inst_valid) begin
            if (timer_irq && mie_mtie && mstatus_mie) begin
                info.take   = 1'b1;
                info.is_irq = 1'b1;
                info.cause  = CAUSE_MTIMER;
            end else if (illegal) begin
                info.take  = 1'b1;
                info.cause = CAUSE_ILLEGAL;
                info.tval  = {32'b0, inst};
            end else if (ebreak) begin
                info.take  = 1'b1;
                info.cause = CAUSE_EBREAK;
                info.tval  = inst_pc;
            end else if (ecall) begin
                info.take  = 1'b1;
                info.cause = CAUSE_ECALL_M;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer between commit, csrfile and IF.
// Accepts a trap or mret in IDLE, writes the CSRs one cycle later and
// redirects fetch the cycle after that.
// Build option: define TRAP_VECTORED_EN to honour mtvec vectored mode for
// interrupts; otherwise mtvec[1:0] is ignored and the base is always used.
module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_pc,
    input  logic [31:0]     inst,
    input  logic            ecall,
    input  logic            ebreak,
    input  logic            illegal,
    input  logic            mret,
    input  logic            timer_irq,
    input  logic [XLEN-1:0] mstatus_rd_data,
    input  logic [XLEN-1:0] mie_rd_data,
    input  logic [XLEN-1:0] mtvec_rd_data,
    input  logic [XLEN-1:0] mepc_rd_data,
    output logic            excp_enter,
    output logic            excp_exit,
    output logic [XLEN-1:0] mstatus_wr_data,
    output logic [XLEN-1:0] mepc_wr_data,
    output logic [XLEN-1:0] mcause_wr_data,
    output logic [XLEN-1:0] mtval_wr_data,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            trap_busy
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            redir_exit_q, redir_exit_d;

    trap_info_t      info;
    logic            accept;
    logic [XLEN-1:0] trap_vector;
    logic            unused_bits;

    assign unused_bits = ^{mie_rd_data, mtvec_rd_data[1:0], info.is_irq};

    trap_cause_enc u_cause_enc (
        .inst_valid  (inst_valid),
        .ecall       (ecall),
        .ebreak      (ebreak),
        .illegal     (illegal),
        .timer_irq   (timer_irq),
        .mie_mtie    (mie_rd_data[MTIE_BIT]),
        .mstatus_mie (mstatus_rd_data[MSTATUS_MIE]),
        .inst_pc     (inst_pc),
        .inst        (inst),
        .info        (info)
    );

    // Something is accepted only in IDLE, either a trap or a plain mret
    assign accept = (state_q == ST_IDLE) && (info.take || (inst_valid && mret));

    // Trap target: base address, optionally offset by 4*cause for interrupts
    always_comb begin
        trap_vector = {mtvec_rd_data[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if ((mtvec_rd_data[1:0] == 2'b01) && cause_q[XLEN-1]) begin
            trap_vector = {mtvec_rd_data[XLEN-1:2], 2'b00} + {cause_q[XLEN-3:0], 2'b00};
        end
`endif
    end

    // Next-state logic and capture of the accepted trap's pc/cause/tval
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cause_d      = cause_q;
        tval_d       = tval_q;
        redir_exit_d = redir_exit_q;
        case (state_q)
            ST_IDLE: begin
                if (info.take) begin
                    pc_d    = inst_pc;
                    cause_d = info.cause;
                    tval_d  = info.tval;
                    state_d = ST_ENTER;
                end else if (inst_valid && mret) begin
                    state_d = ST_EXIT;
                end
            end
            ST_ENTER: begin
                redir_exit_d = 1'b0;
                state_d      = ST_REDIR;
            end
            ST_EXIT: begin
                redir_exit_d = 1'b1;
                state_d      = ST_REDIR;
            end
            ST_REDIR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and trap-record registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            cause_q      <= '0;
            tval_q       <= '0;
            redir_exit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cause_q      <= cause_d;
            tval_q       <= tval_d;
            redir_exit_q <= redir_exit_d;
        end
    end

    // Pulses and data buses; everything is zero outside its pulse and in reset
    always_comb begin
        excp_enter      = 1'b0;
        excp_exit       = 1'b0;
        mstatus_wr_data = '0;
        mepc_wr_data    = '0;
        mcause_wr_data  = '0;
        mtval_wr_data   = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        trap_busy       = 1'b0;
        if (!rst) begin
            trap_busy = accept || (state_q != ST_IDLE);
            case (state_q)
                ST_ENTER: begin
                    excp_enter      = 1'b1;
                    mstatus_wr_data = mstatus_rd_data;
                    mstatus_wr_data[MSTATUS_MPIE] = mstatus_rd_data[MSTATUS_MIE];
                    mstatus_wr_data[MSTATUS_MIE]  = 1'b0;
                    mstatus_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                    mepc_wr_data    = pc_q & ~64'h3;
                    mcause_wr_data  = cause_q;
                    mtval_wr_data   = tval_q;
                end
                ST_EXIT: begin
                    excp_exit       = 1'b1;
                    mstatus_wr_data = mstatus_rd_data;
                    mstatus_wr_data[MSTATUS_MIE]  = mstatus_rd_data[MSTATUS_MPIE];
                    mstatus_wr_data[MSTATUS_MPIE] = 1'b1;
                    mstatus_wr_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                end
                ST_REDIR: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = redir_exit_q ? mepc_rd_data : trap_vector;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected CSR-write and
// redirect events, a negedge monitor pops and compares them whenever the
// DUT pulses, and checks the data buses stay zero otherwise.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic [63:0] inst_pc;
    logic [31:0] inst;
    logic        ecall, ebreak, illegal, mret, timer_irq;
    logic [63:0] mstatus_rd_data, mie_rd_data, mtvec_rd_data, mepc_rd_data;
    logic        excp_enter, excp_exit, redirect_valid, trap_busy;
    logic [63:0] mstatus_wr_data, mepc_wr_data, mcause_wr_data, mtval_wr_data, redirect_pc;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .inst_valid      (inst_valid),
        .inst_pc         (inst_pc),
        .inst            (inst),
        .ecall           (ecall),
        .ebreak          (ebreak),
        .illegal         (illegal),
        .mret            (mret),
        .timer_irq       (timer_irq),
        .mstatus_rd_data (mstatus_rd_data),
        .mie_rd_data     (mie_rd_data),
        .mtvec_rd_data   (mtvec_rd_data),
        .mepc_rd_data    (mepc_rd_data),
        .excp_enter      (excp_enter),
        .excp_exit       (excp_exit),
        .mstatus_wr_data (mstatus_wr_data),
        .mepc_wr_data    (mepc_wr_data),
        .mcause_wr_data  (mcause_wr_data),
        .mtval_wr_data   (mtval_wr_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .trap_busy       (trap_busy)
    );

    localparam int K_ENTER = 1;
    localparam int K_EXIT  = 2;
    localparam int K_REDIR = 3;

    typedef struct {
        int          kind;
        logic [63:0] mstatus;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
        logic [63:0] rpc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

`ifdef TRAP_VECTORED_EN
    localparam logic [63:0] IRQ_TARGET = 64'h8000_041C;
`else
    localparam logic [63:0] IRQ_TARGET = 64'h8000_0400;
`endif

    function void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endfunction

    function void pushEvent(input int kind, input logic [63:0] ms, input logic [63:0] mepc,
                            input logic [63:0] mcause, input logic [63:0] mtval, input logic [63:0] rpc);
        exp_t e;
        e.kind = kind; e.mstatus = ms; e.mepc = mepc;
        e.mcause = mcause; e.mtval = mtval; e.rpc = rpc;
        sbq.push_back(e);
    endfunction

    // Monitor: compare every pulse against the queue head, zero-check otherwise
    always @(negedge clk) begin
        exp_t e;
        if (excp_enter || excp_exit || redirect_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL spurious_pulse: got enter=%0b exit=%0b redir=%0b, expected no pulse",
                         excp_enter, excp_exit, redirect_valid);
            end else begin
                e = sbq.pop_front();
                checkOutput("excp_enter", {63'b0, excp_enter}, 64'(e.kind == K_ENTER));
                checkOutput("excp_exit", {63'b0, excp_exit}, 64'(e.kind == K_EXIT));
                checkOutput("redirect_valid", {63'b0, redirect_valid}, 64'(e.kind == K_REDIR));
                checkOutput("mstatus_wr_data", mstatus_wr_data, e.mstatus);
                checkOutput("mepc_wr_data", mepc_wr_data, e.mepc);
                checkOutput("mcause_wr_data", mcause_wr_data, e.mcause);
                checkOutput("mtval_wr_data", mtval_wr_data, e.mtval);
                checkOutput("redirect_pc", redirect_pc, e.rpc);
            end
        end else begin
            checkOutput("idle_buses_zero",
                        mstatus_wr_data | mepc_wr_data | mcause_wr_data | mtval_wr_data | redirect_pc,
                        64'h0);
        end
    end

    task automatic clearInputs();
        inst_valid = 1'b0; inst_pc = '0; inst = '0;
        ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0; timer_irq = 1'b0;
    endtask

    // One commit-stage instruction for one cycle; waits out the busy window
    task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] iw,
                                 input logic ec, input logic eb, input logic il,
                                 input logic mr, input logic ti, input logic exp_busy);
        @(posedge clk); #1;
        inst_valid = 1'b1; inst_pc = pc; inst = iw;
        ecall = ec; ebreak = eb; illegal = il; mret = mr; timer_irq = ti;
        @(negedge clk);
        checkOutput("trap_busy_accept", {63'b0, trap_busy}, {63'b0, exp_busy});
        @(posedge clk); #1;
        clearInputs();
        if (exp_busy) begin
            @(posedge clk);
            @(posedge clk);
        end
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        mstatus_rd_data = 64'h8; mie_rd_data = 64'h0;
        mtvec_rd_data = 64'h8000_0400; mepc_rd_data = 64'h0;

        // Reset: outputs quiet even with an ecall presented
        repeat (2) @(posedge clk);
        #1;
        inst_valid = 1'b1; ecall = 1'b1; inst_pc = 64'h8000_0000;
        @(negedge clk);
        checkOutput("reset_busy", {63'b0, trap_busy}, 64'h0);
        checkOutput("reset_enter", {63'b0, excp_enter}, 64'h0);
        checkOutput("reset_redirect", {63'b0, redirect_valid}, 64'h0);
        @(posedge clk); #1;
        clearInputs();
        rst = 1'b0;

        // ecall
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0100, 64'd11, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        applyStimulus(64'h8000_0100, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // illegal beats a simultaneous ecall
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0200, 64'd2, 64'hFFFF_FFFF, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        applyStimulus(64'h8000_0200, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // ebreak at a misaligned pc: mepc masked, mtval keeps raw pc
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0300, 64'd3, 64'h8000_0302, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        applyStimulus(64'h8000_0302, 32'h0010_0073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // mret
        mstatus_rd_data = 64'h1880; mepc_rd_data = 64'h8000_0104;
        pushEvent(K_EXIT, 64'h1888, 64'h0, 64'h0, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0104);
        applyStimulus(64'h8000_0700, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // timer irq with simultaneous mret; irq wins, vectored mtvec
        mstatus_rd_data = 64'h8; mie_rd_data = 64'h80; mtvec_rd_data = 64'h8000_0401;
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0500, 64'h8000_0000_0000_0007, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, IRQ_TARGET);
        applyStimulus(64'h8000_0500, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // exception with vectored mtvec still goes to base
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0504, 64'd11, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        applyStimulus(64'h8000_0504, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // timer pending but MIE clear: no trap
        mstatus_rd_data = 64'h0;
        applyStimulus(64'h8000_0508, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // timer pending, MIE set but MTIE clear: no trap
        mstatus_rd_data = 64'h8; mie_rd_data = 64'h0;
        applyStimulus(64'h8000_050C, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // requests during the busy window are dropped
        mtvec_rd_data = 64'h8000_0400;
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0600, 64'd11, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        @(posedge clk); #1;
        inst_valid = 1'b1; inst_pc = 64'h8000_0600; ecall = 1'b1;
        @(posedge clk); #1;
        ecall = 1'b0; ebreak = 1'b1; inst_pc = 64'h8000_0680;
        @(negedge clk);
        checkOutput("trap_busy_enter", {63'b0, trap_busy}, 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("trap_busy_redir", {63'b0, trap_busy}, 64'h1);
        #1;
        clearInputs();
        @(posedge clk);

        // reset while in ENTER: no pulse, back to IDLE
        @(posedge clk); #1;
        inst_valid = 1'b1; inst_pc = 64'h8000_0800; ecall = 1'b1;
        @(posedge clk); #1;
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_enter_pulse", {63'b0, excp_enter}, 64'h0);
        checkOutput("rst_enter_busy", {63'b0, trap_busy}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_busy", {63'b0, trap_busy}, 64'h0);

        // recovery after reset
        mstatus_rd_data = 64'h1888;
        pushEvent(K_ENTER, 64'h1880, 64'h8000_0900, 64'd11, 64'h0, 64'h0);
        pushEvent(K_REDIR, 64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0400);
        applyStimulus(64'h8000_0900, 32'h0000_0073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        checkOutput("scoreboard_drained", 64'(sbq.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
